// File: rtl/decode_stage.sv
// decode_stage: RV32I decode pipeline stage with optional one-entry skid buffer
module decode_stage #(
  parameter int PC_W = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_imm,
  output logic [3:0]      out_alu_op,
  output logic            out_alu_src_imm,
  output logic [2:0]      out_funct3,
  output logic            out_reg_we,
  output logic            out_mem_re,
  output logic            out_mem_we,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal
);
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [3:0]      alu_op;
    logic            alu_src_imm;
    logic [2:0]      funct3;
    logic            reg_we;
    logic            mem_re;
    logic            mem_we;
    logic            branch;
    logic            jump;
    logic            illegal;
  } bundle_t;
  bundle_t d, q;
  logic skid_full, accept, advance, legal;
  logic [31:0] skid_instr, instr, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [PC_W-1:0] skid_pc, pc;
  logic [6:0] f7;
  logic [2:0] f3;
  assign advance  = !out_valid || out_ready;
  assign in_ready = !rst && (SKID ? !skid_full : advance);
  assign accept   = in_valid && in_ready;
  assign instr    = skid_full ? skid_instr : in_instr;
  assign pc       = skid_full ? skid_pc : in_pc;
  assign f7       = instr[31:25];
  assign f3       = instr[14:12];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u    = {instr[31:12], 12'b0};
  assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  // decode the instruction about to enter the output register (skid entry first)
  always_comb begin
    d = '0;
    legal = 1'b1;
    d.pc = pc;
    d.funct3 = f3;
    case (instr[6:0])
      7'b0110011: begin
        d.rs1 = instr[19:15]; d.rs2 = instr[24:20]; d.rd = instr[11:7];
        d.alu_op = {f7[5], f3}; d.reg_we = 1'b1;
        legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
      end
      7'b0010011: begin
        d.rs1 = instr[19:15]; d.rd = instr[11:7];
        d.imm = f3[1:0] == 2'b01 ? {27'b0, instr[24:20]} : imm_i;
        d.alu_op = {f3 == 3'b101 && f7[5], f3}; d.alu_src_imm = 1'b1; d.reg_we = 1'b1;
        legal = f3 == 3'b001 ? f7 == 7'h00 : f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      end
      7'b0000011: begin
        d.rs1 = instr[19:15]; d.rd = instr[11:7]; d.imm = imm_i;
        d.alu_src_imm = 1'b1; d.mem_re = 1'b1; d.reg_we = 1'b1;
        legal = f3 != 3'b011 && f3[2:1] != 2'b11;
      end
      7'b0100011: begin
        d.rs1 = instr[19:15]; d.rs2 = instr[24:20]; d.imm = imm_s;
        d.alu_src_imm = 1'b1; d.mem_we = 1'b1;
        legal = !f3[2] && f3 != 3'b011;
      end
      7'b1100011: begin
        d.rs1 = instr[19:15]; d.rs2 = instr[24:20]; d.imm = imm_b;
        d.alu_op = 4'b1000; d.branch = 1'b1;
        legal = f3[2:1] != 2'b01;
      end
      7'b1101111: begin
        d.rd = instr[11:7]; d.imm = imm_j; d.jump = 1'b1; d.reg_we = 1'b1;
      end
      7'b1100111: begin
        d.rs1 = instr[19:15]; d.rd = instr[11:7]; d.imm = imm_i;
        d.alu_src_imm = 1'b1; d.jump = 1'b1; d.reg_we = 1'b1;
        legal = f3 == 3'b000;
      end
      7'b0110111, 7'b0010111: begin
        d.rd = instr[11:7]; d.imm = imm_u; d.alu_src_imm = 1'b1; d.reg_we = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    d.illegal = !legal;
    {d.reg_we, d.mem_re, d.mem_we, d.branch, d.jump} = {d.reg_we, d.mem_re, d.mem_we, d.branch, d.jump} & {5{legal}};
  end
  // output register refills from skid before input; input parks in skid while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      out_valid <= 1'b0;
      skid_full <= 1'b0;
      skid_instr <= '0;
      skid_pc <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
    end else if (advance) begin
      out_valid <= skid_full || accept;
      if (skid_full || accept) q <= d;
      skid_full <= 1'b0;
    end else if (SKID && accept) begin
      skid_instr <= in_instr;
      skid_pc <= in_pc;
      skid_full <= 1'b1;
    end
  end
  assign out_pc          = q.pc;
  assign out_rs1         = q.rs1;
  assign out_rs2         = q.rs2;
  assign out_rd          = q.rd;
  assign out_imm         = q.imm;
  assign out_alu_op      = q.alu_op;
  assign out_alu_src_imm = q.alu_src_imm;
  assign out_funct3      = q.funct3;
  assign out_reg_we      = q.reg_we;
  assign out_mem_re      = q.mem_re;
  assign out_mem_we      = q.mem_we;
  assign out_branch      = q.branch;
  assign out_jump        = q.jump;
  assign out_illegal     = q.illegal;
endmodule
